// File: rtl/vera_tpg_pkg.sv
// Shared colour constants, mode encodings and bar-colour lookups for vera_tpg.
package vera_tpg_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t C_W75   = 24'hB4B4B4;
  localparam rgb_t C_Y75   = 24'hB4B410;
  localparam rgb_t C_C75   = 24'h10B4B4;
  localparam rgb_t C_G75   = 24'h10B410;
  localparam rgb_t C_M75   = 24'hB410B4;
  localparam rgb_t C_R75   = 24'hB41010;
  localparam rgb_t C_B75   = 24'h1010B4;
  localparam rgb_t C_BLK   = 24'h101010;
  localparam rgb_t C_W100  = 24'hEBEBEB;
  localparam rgb_t C_NEG_I = 24'h10466A;
  localparam rgb_t C_POS_Q = 24'h481076;

  typedef enum logic [2:0] {
    MODE_BARS   = 3'd0,
    MODE_GREY   = 3'd1,
    MODE_CHECK  = 3'd2,
    MODE_SOLID  = 3'd3,
    MODE_SCROLL = 3'd4
  } mode_e;

  function automatic rgb_t bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    return C_W75;
      3'd1:    return C_Y75;
      3'd2:    return C_C75;
      3'd3:    return C_G75;
      3'd4:    return C_M75;
      3'd5:    return C_R75;
      default: return C_B75;
    endcase
  endfunction

  // Reverse-order bars interleaved with black, sitting under the main bars.
  function automatic rgb_t castle_colour(input logic [2:0] b);
    case (b)
      3'd0:    return C_B75;
      3'd2:    return C_M75;
      3'd4:    return C_C75;
      3'd6:    return C_W75;
      default: return C_BLK;
    endcase
  endfunction

endpackage

// File: rtl/vera_tpg_timing.sv
// Pixel enable, raster counters and registered sync/blank/frame_start for vera_tpg.
module vera_tpg_timing #(
  parameter int unsigned H_ACTIVE     = 529,
  parameter int unsigned H_SYNC_START = 544,
  parameter int unsigned H_SYNC_END   = 590,
  parameter int unsigned H_TOTAL      = 638,
  parameter int unsigned V_ACTIVE     = 240,
  parameter int unsigned V_SYNC_START = 245,
  parameter int unsigned V_SYNC_END   = 248,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned CW           = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scandouble,
  output logic          ce_pix,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic [CW-1:0] ly,
  output logic          active,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);

  logic [CW-1:0] v_total;
  logic [CW-1:0] v_active;
  logic [CW-1:0] v_sync_start;
  logic [CW-1:0] v_sync_end;

  always_comb begin
    v_total      = scandouble ? CW'(2 * V_TOTAL)      : CW'(V_TOTAL);
    v_active     = scandouble ? CW'(2 * V_ACTIVE)     : CW'(V_ACTIVE);
    v_sync_start = scandouble ? CW'(2 * V_SYNC_START) : CW'(V_SYNC_START);
    v_sync_end   = scandouble ? CW'(2 * V_SYNC_END)   : CW'(V_SYNC_END);
    ly           = vc >> scandouble;
    active       = (hc < CW'(H_ACTIVE)) && (vc < v_active);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_pix      <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ce_pix <= scandouble | ~ce_pix;
      if (ce_pix) begin
        hblank      <= hc >= CW'(H_ACTIVE);
        hsync       <= (hc >= CW'(H_SYNC_START)) && (hc < CW'(H_SYNC_END));
        vblank      <= vc >= v_active;
        vsync       <= (vc >= v_sync_start) && (vc < v_sync_end);
        frame_start <= (hc == '0) && (vc == '0);
        if (hc == H_LAST) begin
          hc <= '0;
          // >= keeps vc recoverable if scandouble drops while vc is in the doubled range
          vc <= (vc >= v_total - 1'b1) ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vera_tpg.sv
// Video timing and test-pattern generator: raster timing plus five frame-latched patterns.
module vera_tpg
  import vera_tpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 529,
  parameter int unsigned H_SYNC_START = 544,
  parameter int unsigned H_SYNC_END   = 590,
  parameter int unsigned H_TOTAL      = 638,
  parameter int unsigned V_ACTIVE     = 240,
  parameter int unsigned V_SYNC_START = 245,
  parameter int unsigned V_SYNC_END   = 248,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned CHECK_LOG2   = 4,
  parameter int unsigned SCROLL_STEP  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scandouble,
  input  logic [2:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        ce_pix,
  output logic        hblank,
  output logic        vblank,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic [23:0] video
);

  localparam int unsigned CW        = $clog2((H_TOTAL > 2 * V_TOTAL) ? H_TOTAL : 2 * V_TOTAL);
  localparam int unsigned BW        = H_ACTIVE / 7;
  localparam int unsigned SW        = H_ACTIVE / 6;
  localparam int unsigned BAND_BARS = (2 * V_ACTIVE) / 3;
  localparam int unsigned BAND_CAST = (7 * V_ACTIVE) / 9;
  localparam int unsigned GREY_SHIFT = 24;
  localparam logic [63:0] GREY_RECIP =
    ((64'd256 << GREY_SHIFT) + 64'(H_ACTIVE) - 64'd1) / 64'(H_ACTIVE);

  if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL))
  begin : g_bad_h
    $error("vera_tpg: horizontal timing parameters out of order");
  end
  if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL))
  begin : g_bad_v
    $error("vera_tpg: vertical timing parameters out of order");
  end
  if (H_ACTIVE < 7 || SCROLL_STEP >= H_ACTIVE || CHECK_LOG2 >= CW) begin : g_bad_misc
    $error("vera_tpg: pattern parameters out of range");
  end

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] ly;
  logic          active;

  vera_tpg_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .H_SYNC_START(H_SYNC_START),
    .H_SYNC_END  (H_SYNC_END),
    .H_TOTAL     (H_TOTAL),
    .V_ACTIVE    (V_ACTIVE),
    .V_SYNC_START(V_SYNC_START),
    .V_SYNC_END  (V_SYNC_END),
    .V_TOTAL     (V_TOTAL),
    .CW          (CW)
  ) u_timing (
    .clk        (clk),
    .reset_n    (reset_n),
    .scandouble (scandouble),
    .ce_pix     (ce_pix),
    .hc         (hc),
    .vc         (vc),
    .ly         (ly),
    .active     (active),
    .hblank     (hblank),
    .vblank     (vblank),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start)
  );

  function automatic logic [2:0] bar_index(input logic [CW-1:0] x);
    logic [2:0] b;
    b = 3'd6;
    for (int unsigned k = 6; k > 0; k--) begin
      if (x < CW'(k * BW)) b = 3'(k - 1);
    end
    return b;
  endfunction

  function automatic rgb_t bars_pattern(input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (y < CW'(BAND_BARS)) return bar_colour(bar_index(x));
    if (y < CW'(BAND_CAST)) return castle_colour(bar_index(x));
    if (x < CW'(SW))        return C_NEG_I;
    if (x < CW'(2 * SW))    return C_W100;
    if (x < CW'(3 * SW))    return C_POS_Q;
    return C_BLK;
  endfunction

  logic [2:0]    mode_l;
  rgb_t          solid_l;
  logic [CW-1:0] scroll_off;
  logic [CW-1:0] scroll_frame;

  logic          origin;
  logic [2:0]    mode_eff;
  rgb_t          solid_eff;
  logic [CW-1:0] scroll_eff;
  logic [CW:0]   scroll_sum;
  logic [CW-1:0] scroll_next;
  logic [CW:0]   hs_sum;
  logic [CW-1:0] hs;
  logic [39:0]   grey_q;
  logic [7:0]    grey;
  rgb_t          pix;

  // The first pixel of a frame is registered on the same edge that latches the
  // new mode, so it uses the incoming values directly to avoid a one-pixel tear.
  always_comb begin
    origin      = (hc == '0) && (vc == '0);
    mode_eff    = origin ? mode       : mode_l;
    solid_eff   = origin ? solid_rgb  : solid_l;
    scroll_eff  = origin ? scroll_off : scroll_frame;

    scroll_sum  = {1'b0, scroll_off} + (CW + 1)'(SCROLL_STEP);
    scroll_next = (scroll_sum >= (CW + 1)'(H_ACTIVE)) ?
                  CW'(scroll_sum - (CW + 1)'(H_ACTIVE)) : scroll_sum[CW-1:0];

    hs_sum      = {1'b0, hc} + {1'b0, scroll_eff};
    hs          = (hs_sum >= (CW + 1)'(H_ACTIVE)) ?
                  CW'(hs_sum - (CW + 1)'(H_ACTIVE)) : hs_sum[CW-1:0];

    grey_q      = 40'((64'(hc) * GREY_RECIP) >> GREY_SHIFT);
    grey        = (grey_q > 40'd255) ? 8'hFF : grey_q[7:0];

    pix = C_BLK;
    case (mode_eff)
      MODE_BARS:   pix = bars_pattern(hc, ly);
      MODE_GREY:   pix = {3{grey}};
      MODE_CHECK:  pix = (hc[CHECK_LOG2] ^ ly[CHECK_LOG2]) ? C_W100 : C_BLK;
      MODE_SOLID:  pix = solid_eff;
      MODE_SCROLL: pix = bars_pattern(hs, ly);
      default:     pix = C_BLK;
    endcase
  end

  // scroll_frame holds the offset in force for the current frame while
  // scroll_off has already advanced for the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_l       <= '0;
      solid_l      <= '0;
      scroll_off   <= '0;
      scroll_frame <= '0;
      de           <= 1'b0;
      video        <= '0;
    end else if (ce_pix) begin
      de    <= active;
      video <= active ? pix : '0;
      if (origin) begin
        mode_l       <= mode;
        solid_l      <= solid_rgb;
        scroll_frame <= scroll_off;
        scroll_off   <= scroll_next;
      end
    end
  end

endmodule

// File: tb/tb_vera_tpg.sv
// Self-checking bench for vera_tpg on a reduced raster, with a cycle model feeding a scoreboard.
module tb_vera_tpg;

  localparam int unsigned HA   = 37;
  localparam int unsigned HSS  = 40;
  localparam int unsigned HSE  = 44;
  localparam int unsigned HT   = 48;
  localparam int unsigned VA   = 18;
  localparam int unsigned VSS  = 20;
  localparam int unsigned VSE  = 22;
  localparam int unsigned VT   = 23;
  localparam int unsigned CL   = 2;
  localparam int unsigned STEP = 2;

  localparam logic [23:0] BARS [7] = '{24'hB4B4B4, 24'hB4B410, 24'h10B4B4, 24'h10B410,
                                       24'hB410B4, 24'hB41010, 24'h1010B4};
  localparam logic [23:0] CAST [7] = '{24'h1010B4, 24'h101010, 24'hB410B4, 24'h101010,
                                       24'h10B4B4, 24'h101010, 24'hB4B4B4};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        scandouble = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        ce_pix, hblank, vblank, hsync, vsync, de, frame_start;
  logic [23:0] video;

  vera_tpg #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .CHECK_LOG2(CL), .SCROLL_STEP(STEP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .scandouble(scandouble), .mode(mode),
    .solid_rgb(solid_rgb), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start), .video(video)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [30:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic logic [23:0] ref_bars(input int x, input int y);
    int b;
    b = x / (HA / 7);
    if (b > 6) b = 6;
    if (y < (2 * VA) / 3) return BARS[b];
    if (y < (7 * VA) / 9) return CAST[b];
    if (x < HA / 6) return 24'h10466A;
    if (x < 2 * (HA / 6)) return 24'hEBEBEB;
    if (x < 3 * (HA / 6)) return 24'h481076;
    return 24'h101010;
  endfunction

  function automatic logic [23:0] ref_pix(input logic [2:0] md, input logic [23:0] sol,
                                          input int x, input int y, input int scr);
    int g;
    case (md)
      3'd0: return ref_bars(x, y);
      3'd1: begin
        g = (x * 256) / HA;
        if (g > 255) g = 255;
        return {3{8'(g)}};
      end
      3'd2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hEBEBEB : 24'h101010;
      3'd3: return sol;
      3'd4: return ref_bars((x + scr) % HA, y);
      default: return 24'h101010;
    endcase
  endfunction

  // Bench-side raster model
  int          m_hc, m_vc, m_scroll, m_scroll_frame;
  logic        m_ce;
  logic [2:0]  m_mode_l;
  logic [23:0] m_solid_l;
  logic [29:0] m_held;

  task automatic model_reset();
    m_hc = 0; m_vc = 0; m_scroll = 0; m_scroll_frame = 0;
    m_ce = 1'b0; m_mode_l = 3'd0; m_solid_l = 24'h0; m_held = '0;
  endtask

  task automatic tick();
    logic [29:0] nxt;
    logic        nce, fs, hbl, vbl, hsy, vsy, den;
    logic [2:0]  md;
    logic [23:0] sol;
    logic [30:0] e_v, o_v;
    int          vt, mul, ly, scr;
    nxt = m_held;
    nce = scandouble ? 1'b1 : ~m_ce;
    if (m_ce) begin
      mul = scandouble ? 2 : 1;
      vt  = VT * mul;
      ly  = m_vc / mul;
      fs  = (m_hc == 0) && (m_vc == 0);
      md  = fs ? mode : m_mode_l;
      sol = fs ? solid_rgb : m_solid_l;
      scr = fs ? m_scroll : m_scroll_frame;
      hbl = m_hc >= HA;
      hsy = (m_hc >= HSS) && (m_hc < HSE);
      vbl = m_vc >= VA * mul;
      vsy = (m_vc >= VSS * mul) && (m_vc < VSE * mul);
      den = !hbl && !vbl;
      nxt = {hbl, vbl, hsy, vsy, den, fs, den ? ref_pix(md, sol, m_hc, ly, scr) : 24'h0};
      if (fs) begin
        m_mode_l = mode; m_solid_l = solid_rgb;
        m_scroll_frame = m_scroll; m_scroll = (m_scroll + STEP) % HA;
      end
      if (m_hc == HT - 1) begin
        m_hc = 0;
        m_vc = (m_vc == vt - 1) ? 0 : m_vc + 1;
      end else begin
        m_hc++;
      end
    end
    m_ce = nce;
    m_held = nxt;
    sb_q.push_back({nce, nxt});
    @(posedge clk);
    #1;
    e_v = sb_q.pop_front();
    o_v = {ce_pix, hblank, vblank, hsync, vsync, de, frame_start, video};
    chk("outputs", 32'(o_v), 32'(e_v));
  endtask

  task automatic do_reset(input logic sd, input logic [2:0] md);
    #3 reset_n = 1'b0;
    #1 chk("reset_async", 32'({ce_pix, hblank, vblank, hsync, vsync, de, frame_start, video}), 32'd0);
    scandouble = sd;
    mode = md;
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", 32'({ce_pix, hblank, vblank, hsync, vsync, de, frame_start, video}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    sb_q.delete();
  endtask

  task automatic first_fs();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 10);
    chk("first_fs_ticks", 32'(n), 32'd2);
  endtask

  int          st_ce, st_hs, st_vs, st_vb, st_de, st_solid;
  logic [23:0] row0 [HT];
  logic [23:0] col0 [2*VT];

  task automatic frame_stats(input int chg_line, input logic [2:0] chg_mode, input logic [23:0] chg_rgb);
    int guard;
    guard = 0;
    while (!(ce_pix && frame_start) && guard < 5000) begin
      tick();
      guard++;
    end
    chk("frame_sync", 32'(guard < 5000), 32'd1);
    st_ce = 0; st_hs = 0; st_vs = 0; st_vb = 0; st_de = 0; st_solid = 0;
    guard = 0;
    do begin
      if (ce_pix) begin
        if (st_ce < HT) row0[st_ce] = video;
        if ((st_ce % HT) == 0 && (st_ce / HT) < 2 * VT) col0[st_ce / HT] = video;
        if (st_ce == chg_line * HT) begin
          mode = chg_mode;
          solid_rgb = chg_rgb;
        end
        st_ce++;
        st_hs += 32'(hsync);
        st_vs += 32'(vsync);
        st_vb += 32'(vblank);
        st_de += 32'(de);
        if (de && video == 24'h123456) st_solid++;
      end
      tick();
      guard++;
    end while (!(ce_pix && frame_start) && guard < 20000);
    chk("frame_end", 32'(guard < 20000), 32'd1);
  endtask

  initial begin
    int s;

    // single-rate geometry, mode 0
    do_reset(1'b0, 3'd0);
    first_fs();
    frame_stats(-1, 3'd0, 24'h0);
    chk("ce_per_frame", 32'(st_ce), 32'(HT * VT));
    chk("hsync_ce", 32'(st_hs), 32'((HSE - HSS) * VT));
    chk("vsync_ce", 32'(st_vs), 32'((VSE - VSS) * HT));
    chk("vblank_ce", 32'(st_vb), 32'((VT - VA) * HT));
    chk("de_ce", 32'(st_de), 32'(HA * VA));
    chk("bar_hc0", 32'(row0[0]), 32'h00B4B4B4);
    chk("bar_hc_bw", 32'(row0[HA / 7]), 32'h00B4B410);
    chk("bar_last", 32'(row0[HA - 1]), 32'h001010B4);
    chk("blank_first", 32'(row0[HA]), 32'h0);

    // mid-frame switch to solid colour takes effect next frame
    frame_stats(10, 3'd3, 24'h123456);
    chk("solid_early", 32'(st_solid), 32'd0);
    mode = 3'd1;
    frame_stats(-1, 3'd0, 24'h0);
    chk("solid_frame", 32'(st_solid), 32'(HA * VA));
    chk("solid_pix0", 32'(row0[0]), 32'h00123456);
    mode = 3'd2;
    frame_stats(-1, 3'd0, 24'h0);
    chk("grey_last", 32'(row0[HA - 1]), 32'h00F9F9F9);
    mode = 3'd7;
    frame_stats(-1, 3'd0, 24'h0);
    chk("check_hc0", 32'(row0[0]), 32'h00101010);
    chk("check_hc4", 32'(row0[4]), 32'h00EBEBEB);
    frame_stats(-1, 3'd0, 24'h0);
    chk("black_hc5", 32'(row0[5]), 32'h00101010);

    // scandouble geometry and vertical bands on ly
    do_reset(1'b1, 3'd0);
    first_fs();
    frame_stats(-1, 3'd0, 24'h0);
    chk("sd_ce_per_frame", 32'(st_ce), 32'(HT * 2 * VT));
    chk("sd_vsync_ce", 32'(st_vs), 32'(2 * (VSE - VSS) * HT));
    chk("sd_vblank_ce", 32'(st_vb), 32'(2 * (VT - VA) * HT));
    chk("sd_de_ce", 32'(st_de), 32'(HA * 2 * VA));
    chk("sd_band_bars", 32'(col0[2 * ((2 * VA) / 3) - 1]), 32'h00B4B4B4);
    chk("sd_band_cast", 32'(col0[2 * ((2 * VA) / 3)]), 32'h001010B4);

    // scrolling bars through one full wrap of the offset
    do_reset(1'b0, 3'd4);
    first_fs();
    s = 0;
    for (int f = 0; f < 20; f++) begin
      frame_stats(-1, 3'd0, 24'h0);
      chk("scroll_hc0", 32'(row0[0]), 32'(ref_bars(s, 0)));
      s = s + STEP;
      if (s >= HA) s = s - HA;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vera_tpg.md
Name: vera_tpg

Overview:
- Parametrised video timing and test-pattern generator. Successor to the fixed-timing colour-bar demo block.
- Sits at the head of the video path, feeding the scaler/scandoubler with pixel enable, sync, blank and 24-bit RGB.
- Adds configurable raster geometry, a data-enable output, five selectable patterns, frame-latched mode switching, a scrolling pattern and a frame-start strobe.

Parameters:
- H_ACTIVE, 529, visible pixels per line.
- H_SYNC_START, 544, hc at which hsync asserts.
- H_SYNC_END, 590, hc at which hsync deasserts.
- H_TOTAL, 638, pixels per line; hc wraps at H_TOTAL-1.
- V_ACTIVE, 240, visible lines (single-rate).
- V_SYNC_START, 245, line at which vsync asserts.
- V_SYNC_END, 248, line at which vsync deasserts.
- V_TOTAL, 262, lines per frame (single-rate).
- CHECK_LOG2, 4, checkerboard cell size is 2^CHECK_LOG2 pixels.
- SCROLL_STEP, 2, pixels the scroll offset advances per frame.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- scandouble  in  1  1: ce every clk and all V params doubled; 0: ce every 2nd clk.
- mode  in  3  pattern select (0 bars, 1 grey ramp, 2 checker, 3 solid, 4 scrolling bars, 5-7 = black).
- solid_rgb  in  24  colour used by mode 3.
- ce_pix  out  1  pixel clock enable.
- hblank  out  1  horizontal blanking.
- vblank  out  1  vertical blanking.
- hsync  out  1  horizontal sync, active-high.
- vsync  out  1  vertical sync, active-high.
- de  out  1  ~hblank & ~vblank.
- frame_start  out  1  one-ce pulse on the first pixel of a frame.
- video  out  24  RGB888, {R,G,B}.

Behaviour:
- Reset (async, reset_n=0):
  - hc, vc, scroll_off, ce_pix: 0. mode_l: 0 (bars). solid_l: 0.
  - All sync/blank/de/frame_start outputs and video: 0.
- ce_pix: scandouble=1 → 1 every cycle; else toggles each clk. Registered.
- Counters: advance only on cycles where ce_pix=1. hc 0..H_TOTAL-1. vc increments when hc wraps.
  - vc wraps at VT-1, where VT = V_TOTAL<<scandouble. V_SYNC_START, V_SYNC_END and V_ACTIVE are likewise shifted.
  - Line index for pattern purposes is ly = vc>>scandouble.
- Timing outputs are registered from the current hc/vc on each ce cycle and hold between ce cycles.
  - hblank = hc>=H_ACTIVE.
  - hsync = H_SYNC_START<=hc<H_SYNC_END.
  - vblank = vc>=V_ACTIVE'.
  - vsync = V_SYNC_START'<=vc<V_SYNC_END'; hsync and vsync are evaluated independently.
  - de and video are produced in the same register stage, so all outputs are aligned: one-clk latency from counter to pins.
- frame_start: 1 for exactly the ce cycle whose registered hc=0 and vc=0; 0 otherwise.
- Mode latching: mode and solid_rgb are sampled into mode_l/solid_l only at hc=0, vc=0 on ce. A mid-frame change takes effect at the next frame start. No tearing.
- Scroll: at each frame start, scroll_off ← (scroll_off+SCROLL_STEP) mod H_ACTIVE, computed with compare-and-subtract, no divider. Advances in every mode; only mode 4 uses it.
- video = 0 whenever de would be 0. Otherwise, per mode_l:
  - Bar geometry: BW = H_ACTIVE/7 (integer, compile-time). Bar index b = min(hc/BW, 6) via comparator chain.
  - Mode 0, ly < (2*V_ACTIVE)/3: bars B4B4B4, B4B410, 10B4B4, 10B410, B410B4, B41010, 1010B4 for b=0..6.
  - Mode 0, ly < (7*V_ACTIVE)/9: castellations 1010B4, 101010, B410B4, 101010, 10B4B4, 101010, B4B4B4.
  - Mode 0, else: squares with SW = H_ACTIVE/6. hc<SW: 10466A; <2SW: EBEBEB; <3SW: 481076; else 101010.
  - Mode 1: grey ramp, each channel = (hc*256)/H_ACTIVE saturated to 8'hFF. A single constant multiply and shift is allowed; the reciprocal is a localparam.
  - Mode 2: hc[CHECK_LOG2]^ly[CHECK_LOG2] ? EBEBEB : 101010.
  - Mode 3: solid_l.
  - Mode 4: mode 0 with hc replaced by hs = (hc+scroll_off) wrapped mod H_ACTIVE. Vertical bands are unchanged.
- Widths: counters CW = $clog2(max(H_TOTAL, 2*V_TOTAL)) bits. All compares are unsigned.
- Parameter legality, checked by an elaboration assertion: H_ACTIVE<H_SYNC_START<H_SYNC_END<=H_TOTAL, and the same ordering for V.

Decomposition:
- Package vera_tpg_pkg holds:
  - The 24-bit colour constants (C_W75, C_Y75, C_C75, C_G75, C_M75, C_R75, C_B75, C_BLK, C_W100, C_NEG_I, C_POS_Q).
  - Mode encodings MODE_BARS..MODE_SCROLL.
- One sub-module, vera_tpg_timing: ce generation, hc/vc counters, sync/blank/frame_start. It exports hc, vc and ly to the pattern logic in the top.

Test Plan:
- Reset: hold reset_n=0 mid-line, then release → all outputs 0. First frame_start at the first ce; hc resumes from 0.
- Frame geometry (scandouble=0) → ce period 2 clk; 638 ce per line, 262 lines per frame; hsync high for ce hc 544..589; vsync high on lines 245..247; vblank on lines 240..261.
- scandouble=1 → ce constant 1; 524 lines per frame; vsync on lines 490..495; ly=vc>>1 gives bar/castellation switch at vc=320.
- Mode 0 line 0 → video B4B4B4 at hc=0, B4B410 at hc=75, 1010B4 at hc=528, 0 at hc=529.
- Mode changed 0→3 with solid_rgb=123456 at line 100 → bars continue to end of frame; the next frame is all 123456 within de.
- Mode 4 → scroll_off 0,2,4,... per frame and wraps to 1 after reaching 528. Verify the hc=0 colour equals the mode-0 colour at hc=scroll_off.
